// File: rtl/ctr_stream_out.sv
// ---------------------------------------------------------------------------
// ctr_stream_out
//
// Buffers iteration counts from the mandelbrot core in a small show-ahead
// FIFO and tags each word with its frame position. The position (x, y)
// advances on every new_ctr strobe, even when the pixel has to be dropped
// because the FIFO is full, so the tags stay aligned with the raster.
//
// Ports:
//   clk        - the one clock
//   rst_n      - synchronous, active-low reset
//   ctr_in     - iteration count from the core
//   new_ctr    - one-cycle strobe, ctr_in valid this cycle
//   out_ready  - consumer accepts the current word
//   out_valid  - a word is available (FIFO not empty)
//   out_ctr    - oldest buffered iteration count
//   out_max    - oldest count is saturated (all ones)
//   out_sof    - oldest word is pixel (0,0)
//   out_eol    - oldest word is the last pixel of its line
//   overflow   - sticky flag, at least one pixel was dropped
//   fill       - current FIFO occupancy
// ---------------------------------------------------------------------------
module ctr_stream_out #(
   parameter int CTRWIDTH = 7,
   parameter int WIDTH    = 64,
   parameter int HEIGHT   = 64,
   parameter int DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CTRWIDTH-1:0]      ctr_in,
   input  logic                     new_ctr,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [CTRWIDTH-1:0]      out_ctr,
   output logic                     out_max,
   output logic                     out_sof,
   output logic                     out_eol,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
   localparam logic [FW-1:0] FULL   = FW'(DEPTH);

   typedef struct packed {
      logic                max;
      logic                sof;
      logic                eol;
      logic [CTRWIDTH-1:0] ctr;
   } entry_t;

   logic [XW-1:0] x;
   logic [YW-1:0] y;

   entry_t        mem [DEPTH];
   entry_t        wr_entry;
   entry_t        rd_entry;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [FW-1:0] count;

   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;

   // Handshake decode. A full FIFO can still accept a pixel when the
   // consumer pops in the same cycle, which is why push looks at pop.
   // The entry tags use the position before this cycle's increment.
   always_comb begin
      empty        = (count == '0);
      full         = (count == FULL);
      pop          = !empty && out_ready;
      push         = new_ctr && (!full || pop);
      drop         = new_ctr && !push;
      wr_entry.ctr = ctr_in;
      wr_entry.max = &ctr_in;
      wr_entry.sof = (x == '0) && (y == '0);
      wr_entry.eol = (x == X_LAST);
   end

   // Raster position: advances on every strobe, stored or dropped, so the
   // first pixel after a drop still lands at the right place in the frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (new_ctr) begin
         if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST) begin
               y <= '0;
            end else begin
               y <= y + 1'b1;
            end
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of
   // two; the separate count distinguishes full from empty when they meet.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage array needs no reset: its contents are never visible while
   // the FIFO is empty, and reset always empties it.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Show-ahead output: the oldest entry is always on the bus, and the data
   // outputs are forced to zero when there is nothing valid to show.
   always_comb begin
      rd_entry  = mem[rd_ptr];
      out_valid = !empty;
      out_ctr   = '0;
      out_max   = 1'b0;
      out_sof   = 1'b0;
      out_eol   = 1'b0;
      if (!empty) begin
         out_ctr = rd_entry.ctr;
         out_max = rd_entry.max;
         out_sof = rd_entry.sof;
         out_eol = rd_entry.eol;
      end
      fill = count;
   end

endmodule

// File: tb/tb_ctr_stream_out.sv
// ---------------------------------------------------------------------------
// tb_ctr_stream_out
//
// Bench for ctr_stream_out with a small raster (4x2) and a 4-entry FIFO.
// A queue-based model tracks what the FIFO must contain from a plain pixel
// counter; the compare process checks every output each cycle against it,
// while directed scenarios pin specific literal values.
// ---------------------------------------------------------------------------
module tb_ctr_stream_out;

   localparam int CW = 7;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] ctr_in;
   logic          new_ctr;
   logic          out_ready;
   logic          out_valid;
   logic [CW-1:0] out_ctr;
   logic          out_max;
   logic          out_sof;
   logic          out_eol;
   logic          overflow;
   logic [$clog2(D):0] fill;

   int total = 0;
   int bad   = 0;

   logic [CW+2:0] exp_q[$];
   int            pix_idx = 0;
   logic          exp_ovf = 1'b0;
   logic          armed   = 1'b0;

   ctr_stream_out #(
      .CTRWIDTH(CW),
      .WIDTH(W),
      .HEIGHT(H),
      .DEPTH(D)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ctr_in(ctr_in),
      .new_ctr(new_ctr),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_ctr(out_ctr),
      .out_max(out_max),
      .out_sof(out_sof),
      .out_eol(out_eol),
      .overflow(overflow),
      .fill(fill)
   );

   always #5 clk = ~clk;

   // Expected tag word {max, sof, eol, ctr} for the idx-th pixel since reset.
   function automatic logic [CW+2:0] make_word(input logic [CW-1:0] c, input int idx);
      int px;
      px = idx % (W * H);
      return {(c == {CW{1'b1}}), (px == 0), ((px % W) == W - 1), c};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: updates on each rising edge from the inputs sampled there.
   initial begin
      logic          do_pop;
      logic          can_push;
      logic [CW+2:0] w;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            exp_q.delete();
            pix_idx = 0;
            exp_ovf = 1'b0;
            armed   = 1'b1;
         end else if (armed) begin
            do_pop   = (exp_q.size() != 0) && out_ready;
            can_push = (exp_q.size() < D) || do_pop;
            w        = make_word(ctr_in, pix_idx);
            if (do_pop) void'(exp_q.pop_front());
            if (new_ctr) begin
               if (can_push) exp_q.push_back(w);
               else          exp_ovf = 1'b1;
               pix_idx++;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model, away from the edge.
   initial begin
      logic [CW+2:0] head;
      forever begin
         @(negedge clk);
         if (armed) begin
            head = (exp_q.size() != 0) ? exp_q[0] : '0;
            checkOutput("model_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            checkOutput("model_word", 32'({out_max, out_sof, out_eol, out_ctr}), 32'(head));
            checkOutput("model_fill", 32'(fill), 32'(exp_q.size()));
            checkOutput("model_overflow", 32'(overflow), 32'(exp_ovf));
         end
      end
   end

   // Drive one cycle of inputs, let the edge take them, return at the next negedge.
   task automatic applyStimulus(input logic nc, input logic [CW-1:0] c, input logic rdy);
      new_ctr   = nc;
      ctr_in    = c;
      out_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      new_ctr   = 1'b0;
   endtask

   // Reset with strobes active so that ignoring them during reset is exercised.
   task automatic applyReset(input int cycles);
      rst_n     = 1'b0;
      new_ctr   = 1'b1;
      ctr_in    = 7'd77;
      out_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      new_ctr   = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      new_ctr   = 1'b0;
      ctr_in    = '0;
      out_ready = 1'b0;

      // Reset state
      applyReset(2);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_fill", 32'(fill), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_ctr", 32'(out_ctr), 32'd0);

      // Basic push with one-cycle latency
      applyStimulus(1'b1, 7'd5, 1'b1);
      checkOutput("basic_valid", 32'(out_valid), 32'd1);
      checkOutput("basic_ctr", 32'(out_ctr), 32'd5);
      checkOutput("basic_sof", 32'(out_sof), 32'd1);
      checkOutput("basic_eol", 32'(out_eol), 32'd0);
      checkOutput("basic_max", 32'(out_max), 32'd0);
      applyStimulus(1'b0, 7'd0, 1'b1);
      checkOutput("basic_drained", 32'(out_valid), 32'd0);

      // Frame tagging over 9 pixels of a 4x2 frame
      applyReset(1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, CW'(i + 10), 1'b1);
         checkOutput("frame_ctr", 32'(out_ctr), 32'(i + 10));
         checkOutput("frame_eol", 32'(out_eol), 32'(i == 3 || i == 7));
         checkOutput("frame_sof", 32'(out_sof), 32'(i == 0 || i == 8));
      end
      checkOutput("frame_overflow", 32'(overflow), 32'd0);
      applyStimulus(1'b0, 7'd0, 1'b1);

      // Overflow: six pushes into a four-deep FIFO with no consumer
      applyReset(1);
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, CW'(i), 1'b0);
      checkOutput("ovf_fill", 32'(fill), 32'd4);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         checkOutput("ovf_drain", 32'(out_ctr), 32'(i));
         applyStimulus(1'b0, 7'd0, 1'b1);
      end
      checkOutput("ovf_empty", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 7'd20, 1'b1);
      checkOutput("ovf_pos6_eol", 32'(out_eol), 32'd0);
      checkOutput("ovf_pos6_sof", 32'(out_sof), 32'd0);
      applyStimulus(1'b1, 7'd21, 1'b1);
      checkOutput("ovf_pos7_ctr", 32'(out_ctr), 32'd21);
      checkOutput("ovf_pos7_eol", 32'(out_eol), 32'd1);
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);
      applyStimulus(1'b0, 7'd0, 1'b1);

      // Simultaneous push and pop while full
      applyReset(1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, CW'(30 + i), 1'b0);
      applyStimulus(1'b1, 7'd34, 1'b1);
      checkOutput("simul_fill", 32'(fill), 32'd4);
      checkOutput("simul_overflow", 32'(overflow), 32'd0);
      checkOutput("simul_head", 32'(out_ctr), 32'd31);

      // Saturated count held under backpressure
      applyReset(1);
      applyStimulus(1'b1, 7'd127, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("sat_max", 32'(out_max), 32'd1);
         checkOutput("sat_ctr", 32'(out_ctr), 32'd127);
         if (i < 2) applyStimulus(1'b0, 7'd0, 1'b0);
      end
      applyStimulus(1'b0, 7'd0, 1'b1);
      checkOutput("sat_popped", 32'(out_valid), 32'd0);

      // Reset mid-operation with data and overflow pending
      applyReset(1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, CW'(40 + i), 1'b0);
      applyStimulus(1'b0, 7'd0, 1'b1);
      checkOutput("mid_pre_fill", 32'(fill), 32'd3);
      checkOutput("mid_pre_ovf", 32'(overflow), 32'd1);
      applyReset(1);
      checkOutput("mid_fill", 32'(fill), 32'd0);
      checkOutput("mid_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_ovf", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 7'd9, 1'b0);
      checkOutput("mid_sof", 32'(out_sof), 32'd1);
      checkOutput("mid_ctr", 32'(out_ctr), 32'd9);

      // Mixed traffic pattern, checked by the model every cycle
      applyReset(1);
      for (int i = 0; i < 80; i++) begin
         applyStimulus((i % 3) != 2, CW'((i * 37) % 128), (i % 5) < 2);
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 7'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL timeout: actual=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
